eth_pkt_commit_fifo: RTL and testbench
======================================

ETH_PKT_COMMIT_FIFO -- requirements
Module: eth_pkt_commit_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: payload width, 1..256.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: depth 2**ADDR_WIDTH words, 4..10.
REQ-003 SHALL have parameter OUT_REG, default 0: 1 adds one output register stage on the read path.
REQ-004 SHALL have parameter ALMOST_FULL_NUM, default 1020: almost_full threshold in words.
REQ-005 SHALL have parameter ALMOST_EMPTY_NUM, default 4: almost_empty threshold in words.
REQ-006 SHALL have ports, one clock, reset synchronous active-high:
 clk  in  1  sole clock, all logic on rising edge
 rst  in  1  synchronous active-high reset
 wr_en  in  1  write request
 wr_data  in  DATA_WIDTH  write word
 wr_eop  in  1  qualifies wr_en: last word of packet
 wr_drop  in  1  discard current uncommitted packet
 full  out  1  no free word
 almost_full  out  1  wr_water_level >= ALMOST_FULL_NUM
 wr_water_level  out  ADDR_WIDTH+1  words held, committed plus uncommitted
 overflow  out  1  one-cycle pulse: wr_en while full
 rd_en  in  1  read request
 rd_data  out  DATA_WIDTH  read word
 rd_eop  out  1  eop flag of rd_data
 rd_valid  out  1  rd_data/rd_eop valid this cycle
 empty  out  1  no committed word
 almost_empty  out  1  rd_water_level <= ALMOST_EMPTY_NUM
 rd_water_level  out  ADDR_WIDTH+1  committed words not yet read
 underflow  out  1  one-cycle pulse: rd_en while empty
 pkt_cnt  out  ADDR_WIDTH+1  complete packets stored, not fully read

Function
REQ-007 SHALL store {eop, data}, DATA_WIDTH+1 bits per entry; pointers wr_ptr, commit_ptr, rd_ptr are ADDR_WIDTH+1 bits with wrap bit, modulo-2**(ADDR_WIDTH+1) arithmetic.
REQ-008 SHALL derive full = (wr_ptr - rd_ptr == 2**ADDR_WIDTH), empty = (commit_ptr == rd_ptr), wr_water_level = wr_ptr - rd_ptr, rd_water_level = commit_ptr - rd_ptr, all from registered pointers, combinationally.
REQ-009 SHALL accept a write when wr_en=1, full=0, state ACCUM or IDLE, wr_drop=0; accepted write increments wr_ptr; full is evaluated before a same-cycle read, so a write at full is rejected even if a read occurs.
REQ-010 SHALL on accepted write with wr_eop=1 set commit_ptr <= wr_ptr+1 and state IDLE; committed words become readable (empty deasserts) the cycle after.
REQ-011 SHALL implement write state machine IDLE (no partial packet) -> ACCUM (first non-eop word accepted) -> IDLE (eop accepted or wr_drop); any state -> DISCARD on wr_en while full; DISCARD -> IDLE on wr_en&wr_eop or wr_drop.
REQ-012 SHALL on entering DISCARD pulse overflow and rewind wr_ptr <= commit_ptr; in DISCARD all writes, including the terminating eop word, are ignored.
REQ-013 SHALL on wr_drop=1 rewind wr_ptr <= commit_ptr; wr_drop overrides a same-cycle wr_en (word ignored, no overflow).
REQ-014 SHALL accept a read when rd_en=1 and empty=0; rd_ptr increments; with OUT_REG=0 rd_data/rd_eop/rd_valid appear 1 cycle after the accepted read, with OUT_REG=1 after 2 cycles; rd_valid=0 otherwise, rd_data holds last value.
REQ-015 SHALL pulse underflow on rd_en while empty; rd_ptr unchanged; a same-cycle commit does not make that read valid.
REQ-016 SHALL increment pkt_cnt on commit and decrement on accepted read of an eop entry; both in one cycle leaves it unchanged.
REQ-017 SHALL never alter committed data by drop, overflow or discard.

Reset
REQ-018 SHALL on rst=1 at a rising edge clear all pointers, pkt_cnt, read pipeline, state to IDLE; rd_data=0, rd_eop=0, rd_valid=0, overflow=0, underflow=0, giving empty=1, full=0, levels 0, almost_empty=1, almost_full=(ALMOST_FULL_NUM==0).
REQ-019 SHALL discard all stored data, committed or not, on reset mid-operation; rst overrides all same-cycle requests; RAM contents need not be cleared.

Structure
REQ-020 SHALL take state encoding (IDLE=2'd0, ACCUM=2'd1, DISCARD=2'd2) and parameter defaults from shared package eth_fifo_pkg.
REQ-021 SHALL instantiate one sub-module eth_fifo_sdpram: simple dual-port RAM, 1 write port, 1 synchronous read port, width DATA_WIDTH+1, depth 2**ADDR_WIDTH.

Verification (ADDR_WIDTH=4, DATA_WIDTH=32, ALMOST_FULL_NUM=12, ALMOST_EMPTY_NUM=2 unless noted)
REQ-022 Write packet 1..5 (eop on 5), then read 5 -> empty=0 cycle after eop; rd_data 1..5 in order, rd_eop only on 5; pkt_cnt 1 then 0; OUT_REG=1 adds exactly one cycle.
REQ-023 Write 3 words, assert wr_drop, write packet 9,10(eop) -> only 9,10 read back; wr_water_level 3 then 0 then 2.
REQ-024 Write 17 words no eop -> overflow pulses once on word 17, wr_water_level=0, words 18..20(eop on 20) ignored, next packet 7(eop) read back alone.
REQ-025 Fill 16 committed words, rd_en and wr_en same cycle at full -> write rejected, read accepted, full=0 next cycle; almost_full=1 at 12 words, almost_empty=1 at <=2.
REQ-026 rd_en on empty -> underflow pulse, rd_valid=0; commit and eop-read same cycle -> pkt_cnt unchanged.
REQ-027 Assert rst mid-packet with 2 packets committed -> next cycle empty=1, pkt_cnt=0, levels 0, state IDLE, new packet passes intact.

Source files
------------

// File: rtl/eth_fifo_pkg.sv
// eth_fifo_pkg: shared defaults and write-side state encoding for the
// packet-commit FIFO family.
package eth_fifo_pkg;

  localparam int DEF_DATA_WIDTH       = 32;
  localparam int DEF_ADDR_WIDTH       = 10;
  localparam int DEF_OUT_REG          = 0;
  localparam int DEF_ALMOST_FULL_NUM  = 1020;
  localparam int DEF_ALMOST_EMPTY_NUM = 4;

  // IDLE: no partial packet, ACCUM: packet being collected,
  // DISCARD: overflowed packet being thrown away until its eop or a drop.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } wr_state_e;

endpackage

// File: rtl/eth_fifo_sdpram.sv
// eth_fifo_sdpram: simple dual-port RAM, one write port and one registered
// read port. Only the read register is reset; the array keeps its contents.
module eth_fifo_sdpram #(
  parameter int WIDTH      = 33,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

  // Write port: store the word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port: registered read, holds its value when no read is requested.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/eth_pkt_commit_fifo.sv
// eth_pkt_commit_fifo: packet-commit FIFO. Words of a packet become visible
// to the reader only after the eop word is written; a partial packet can be
// dropped by the writer and is thrown away automatically on overflow.
module eth_pkt_commit_fifo
  import eth_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH       = DEF_ADDR_WIDTH,
  parameter int OUT_REG          = DEF_OUT_REG,
  parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
  parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_eop,
  input  logic                  wr_drop,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_water_level,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_eop,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_water_level,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   pkt_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};

  wr_state_e state, state_next;

  logic [ADDR_WIDTH:0] wr_ptr, commit_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] wr_level, rd_level;
  logic [DEPTH-1:0]    eop_flags;
  logic [DATA_WIDTH:0] ram_q;
  logic                ram_valid;
  logic                wr_accept, wr_commit, wr_rewind, enter_discard;
  logic                rd_accept, rd_is_eop;

  assign wr_level       = wr_ptr - rd_ptr;
  assign rd_level       = commit_ptr - rd_ptr;
  assign full           = (wr_level == DEPTH_P);
  assign empty          = (commit_ptr == rd_ptr);
  assign wr_water_level = wr_level;
  assign rd_water_level = rd_level;
  assign almost_full    = int'(wr_level) >= ALMOST_FULL_NUM;
  assign almost_empty   = int'(rd_level) <= ALMOST_EMPTY_NUM;
  assign rd_accept      = rd_en && !empty;
  assign rd_is_eop      = eop_flags[rd_ptr[ADDR_WIDTH-1:0]];

  // Write state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Write next-state: drop wins, then overflow, then a normal write.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: begin
        if (wr_drop)            state_next = IDLE;
        else if (wr_en && full) state_next = DISCARD;
        else if (wr_en)         state_next = wr_eop ? IDLE : ACCUM;
      end
      DISCARD: begin
        if (wr_drop || (wr_en && wr_eop)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write-side actions decoded from the current state and requests.
  always_comb begin
    wr_accept     = 1'b0;
    wr_commit     = 1'b0;
    wr_rewind     = 1'b0;
    enter_discard = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (wr_drop) begin
          wr_rewind = 1'b1;
        end else if (wr_en && full) begin
          enter_discard = 1'b1;
          wr_rewind     = 1'b1;
        end else if (wr_en) begin
          wr_accept = 1'b1;
          wr_commit = wr_eop;
        end
      end
      DISCARD: wr_rewind = wr_drop;
      default: ;
    endcase
  end

  // Write and commit pointers; a rewind throws away the uncommitted tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      if (wr_rewind)      wr_ptr <= commit_ptr;
      else if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (wr_commit)      commit_ptr <= wr_ptr + 1'b1;
    end
  end

  // Read pointer advances on every accepted read.
  always_ff @(posedge clk) begin
    if (rst)            rd_ptr <= '0;
    else if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
  end

  // Eop shadow so the packet count can drop in the same cycle the eop is read.
  always_ff @(posedge clk) begin
    if (wr_accept) eop_flags[wr_ptr[ADDR_WIDTH-1:0]] <= wr_eop;
  end

  // Packet counter: up on commit, down on reading an eop word.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else begin
      case ({wr_commit, rd_accept && rd_is_eop})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

  // Error pulses and the valid flag matching the RAM read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ram_valid <= 1'b0;
    end else begin
      overflow  <= enter_discard;
      underflow <= rd_en && empty;
      ram_valid <= rd_accept;
    end
  end

  eth_fifo_sdpram #(
    .WIDTH      (DATA_WIDTH + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data ({wr_eop, wr_data}),
    .rd_en   (rd_accept),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (ram_q)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH:0] out_q;
      logic                out_valid;

      // Extra output stage; holds the last word when nothing new arrives.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_q     <= '0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= ram_valid;
          if (ram_valid) out_q <= ram_q;
        end
      end

      assign {rd_eop, rd_data} = out_q;
      assign rd_valid          = out_valid;
    end else begin : g_no_out_reg
      assign {rd_eop, rd_data} = ram_q;
      assign rd_valid          = ram_valid;
    end
  endgenerate

endmodule

// File: tb/tb_eth_pkt_commit_fifo.sv
// tb_eth_pkt_commit_fifo: drives two FIFOs (OUT_REG=0 and OUT_REG=1) with the
// same stimulus; a queue-based packet model predicts levels, flags and read data.
module tb_eth_pkt_commit_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int AF    = 12;
  localparam int AE    = 2;
  localparam int DEPTH = 16;
  localparam int NV    = 20;

  typedef struct {
    logic        we;
    logic [31:0] d;
    logic        eop;
    logic        drop;
    logic        re;
    int          wl;
    int          rl;
    int          pk;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        eop;
    int          cyc;
  } sb_t;

  logic clk_tb = 1'b0;
  logic tb_rst;
  logic wr_en, wr_eop, wr_drop, rd_en;
  logic [DW-1:0] wr_data;

  logic full0, af0, ovf0, rdv0, rde0, empty0, ae0, unf0;
  logic full1, af1, ovf1, rdv1, rde1, empty1, ae1, unf1;
  logic [AW:0] wl0, rl0, pkt0, wl1, rl1, pkt1;
  logic [DW-1:0] rdd0, rdd1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  vec_t vecs[NV];
  logic [32:0] comm_q[$];
  logic [32:0] pend_q[$];
  sb_t sb0[$];
  sb_t sb1[$];
  logic m_disc, m_ovf, m_unf;

  always #5 clk_tb = ~clk_tb;

  always @(posedge clk_tb) cyc <= cyc + 1;

  eth_pkt_commit_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0),
    .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
  ) dut0 (
    .clk(clk_tb), .rst(tb_rst), .wr_en(wr_en), .wr_data(wr_data), .wr_eop(wr_eop),
    .wr_drop(wr_drop), .full(full0), .almost_full(af0), .wr_water_level(wl0),
    .overflow(ovf0), .rd_en(rd_en), .rd_data(rdd0), .rd_eop(rde0), .rd_valid(rdv0),
    .empty(empty0), .almost_empty(ae0), .rd_water_level(rl0), .underflow(unf0),
    .pkt_cnt(pkt0)
  );

  eth_pkt_commit_fifo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1),
    .ALMOST_FULL_NUM(AF), .ALMOST_EMPTY_NUM(AE)
  ) dut1 (
    .clk(clk_tb), .rst(tb_rst), .wr_en(wr_en), .wr_data(wr_data), .wr_eop(wr_eop),
    .wr_drop(wr_drop), .full(full1), .almost_full(af1), .wr_water_level(wl1),
    .overflow(ovf1), .rd_en(rd_en), .rd_data(rdd1), .rd_eop(rde1), .rd_valid(rdv1),
    .empty(empty1), .almost_empty(ae1), .rd_water_level(rl1), .underflow(unf1),
    .pkt_cnt(pkt1)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int we, input int d, input int e, input int dr,
                              input int re, input int wl, input int rl, input int pk);
    vec_t v;
    v.we = (we != 0); v.d = 32'(d); v.eop = (e != 0); v.drop = (dr != 0);
    v.re = (re != 0); v.wl = wl; v.rl = rl; v.pk = pk;
    return v;
  endfunction

  // Packet model: reads see only words committed before this cycle.
  task automatic model_step(input logic we, input logic [31:0] d, input logic e,
                            input logic dr, input logic re);
    logic [32:0] w;
    sb_t s;
    int total;
    total = comm_q.size() + pend_q.size();
    m_unf = re && (comm_q.size() == 0);
    m_ovf = 1'b0;
    if (re && comm_q.size() != 0) begin
      w = comm_q.pop_front();
      s.data = w[31:0]; s.eop = w[32];
      s.cyc = cyc + 1; sb0.push_back(s);
      s.cyc = cyc + 2; sb1.push_back(s);
    end
    if (m_disc) begin
      if (dr || (we && e)) m_disc = 1'b0;
    end else if (dr) begin
      pend_q.delete();
    end else if (we && total == DEPTH) begin
      m_ovf = 1'b1; m_disc = 1'b1; pend_q.delete();
    end else if (we) begin
      pend_q.push_back({e, d});
      if (e) begin
        foreach (pend_q[i]) comm_q.push_back(pend_q[i]);
        pend_q.delete();
      end
    end
  endtask

  task automatic model_reset();
    comm_q.delete(); pend_q.delete(); sb0.delete(); sb1.delete();
    m_disc = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic check_dut(input string tag, input int wl, input int rl, input int pk,
                           input int emp, input int ful, input int af, input int ae,
                           input int ovf, input int unf);
    int ewl, erl, epk;
    ewl = comm_q.size() + pend_q.size();
    erl = comm_q.size();
    epk = 0;
    foreach (comm_q[i]) if (comm_q[i][32]) epk++;
    check({tag, "_wr_level"}, wl, ewl);
    check({tag, "_rd_level"}, rl, erl);
    check({tag, "_pkt_cnt"}, pk, epk);
    check({tag, "_empty"}, emp, int'(erl == 0));
    check({tag, "_full"}, ful, int'(ewl == DEPTH));
    check({tag, "_almost_full"}, af, int'(ewl >= AF));
    check({tag, "_almost_empty"}, ae, int'(erl <= AE));
    check({tag, "_overflow"}, ovf, int'(m_ovf));
    check({tag, "_underflow"}, unf, int'(m_unf));
  endtask

  task automatic check_output();
    check_dut("dut0", int'(wl0), int'(rl0), int'(pkt0), int'(empty0), int'(full0),
              int'(af0), int'(ae0), int'(ovf0), int'(unf0));
    check_dut("dut1", int'(wl1), int'(rl1), int'(pkt1), int'(empty1), int'(full1),
              int'(af1), int'(ae1), int'(ovf1), int'(unf1));
  endtask

  task automatic apply_stimulus(input logic we, input logic [31:0] d, input logic e,
                                input logic dr, input logic re);
    wr_en = we; wr_data = d; wr_eop = e; wr_drop = dr; rd_en = re;
    model_step(we, d, e, dr, re);
    @(posedge clk_tb); #1;
    wr_en = 1'b0; wr_data = '0; wr_eop = 1'b0; wr_drop = 1'b0; rd_en = 1'b0;
    check_output();
  endtask

  // Read-data scoreboard: every valid word must match the next expected one on time.
  always @(negedge clk_tb) begin
    sb_t e;
    if (rdv0 === 1'b1) begin
      if (sb0.size() == 0) begin
        check("dut0_unexpected_valid", 1, 0);
      end else begin
        e = sb0.pop_front();
        check("dut0_rd_data", int'(rdd0), int'(e.data));
        check("dut0_rd_eop", int'(rde0), int'(e.eop));
        check("dut0_rd_cycle", cyc, e.cyc);
      end
    end
    if (rdv1 === 1'b1) begin
      if (sb1.size() == 0) begin
        check("dut1_unexpected_valid", 1, 0);
      end else begin
        e = sb1.pop_front();
        check("dut1_rd_data", int'(rdd1), int'(e.data));
        check("dut1_rd_eop", int'(rde1), int'(e.eop));
        check("dut1_rd_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Packet 1..5 read back, then partial packet dropped and 9,10 read back.
    vecs[0]  = mk(1, 1, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk(1, 2, 0, 0, 0, 2, 0, 0);
    vecs[2]  = mk(1, 3, 0, 0, 0, 3, 0, 0);
    vecs[3]  = mk(1, 4, 0, 0, 0, 4, 0, 0);
    vecs[4]  = mk(1, 5, 1, 0, 0, 5, 5, 1);
    vecs[5]  = mk(0, 0, 0, 0, 1, 4, 4, 1);
    vecs[6]  = mk(0, 0, 0, 0, 1, 3, 3, 1);
    vecs[7]  = mk(0, 0, 0, 0, 1, 2, 2, 1);
    vecs[8]  = mk(0, 0, 0, 0, 1, 1, 1, 1);
    vecs[9]  = mk(0, 0, 0, 0, 1, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(1, 11, 0, 0, 0, 1, 0, 0);
    vecs[12] = mk(1, 12, 0, 0, 0, 2, 0, 0);
    vecs[13] = mk(1, 13, 0, 0, 0, 3, 0, 0);
    vecs[14] = mk(1, 99, 0, 1, 0, 0, 0, 0);
    vecs[15] = mk(1, 9, 0, 0, 0, 1, 0, 0);
    vecs[16] = mk(1, 10, 1, 0, 0, 2, 2, 1);
    vecs[17] = mk(0, 0, 0, 0, 1, 1, 1, 1);
    vecs[18] = mk(0, 0, 0, 0, 1, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0);

    tb_rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_eop = 1'b0; wr_drop = 1'b0; rd_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_tb);
    #1;
    tb_rst = 1'b0;
    check("rst_rd_data0", int'(rdd0), 0);
    check("rst_rd_eop0", int'(rde0), 0);
    check("rst_rd_valid0", int'(rdv0), 0);
    check("rst_rd_data1", int'(rdd1), 0);
    check("rst_rd_valid1", int'(rdv1), 0);
    check_output();

    for (int i = 0; i < NV; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].d, vecs[i].eop, vecs[i].drop, vecs[i].re);
      check($sformatf("vec%0d_wr_level", i), int'(wl0), vecs[i].wl);
      check($sformatf("vec%0d_rd_level", i), int'(rl0), vecs[i].rl);
      check($sformatf("vec%0d_pkt_cnt", i), int'(pkt0), vecs[i].pk);
    end
    apply_stimulus(0, 0, 0, 0, 0);

    // Overflow: 17th word of an unterminated packet, rest of it ignored.
    for (int i = 0; i < 17; i++) apply_stimulus(1'b1, 32'(100 + i), 1'b0, 1'b0, 1'b0);
    check("ovf_pulse", int'(ovf0), 1);
    check("ovf_wr_level", int'(wl0), 0);
    apply_stimulus(1, 117, 0, 0, 0);
    check("ovf_single_pulse", int'(ovf0), 0);
    apply_stimulus(1, 118, 0, 0, 0);
    apply_stimulus(1, 119, 1, 0, 0);
    apply_stimulus(1, 7, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0);

    // Full: 16 committed words, then a write and a read in the same cycle.
    for (int i = 0; i < 16; i++)
      apply_stimulus(1'b1, 32'(200 + i), logic'((i % 4) == 3), 1'b0, 1'b0);
    check("full_at_16", int'(full0), 1);
    apply_stimulus(1, 999, 1, 0, 1);
    check("full_cleared_by_read", int'(full0), 0);
    check("full_write_rejected", int'(wl0), 15);
    for (int i = 0; i < 15; i++) apply_stimulus(0, 0, 0, 0, 1);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0);
    apply_stimulus(1, 998, 1, 0, 0);

    // Underflow and same-cycle commit / eop-read.
    apply_stimulus(0, 0, 0, 0, 1);
    check("unf_pulse", int'(unf0), 1);
    apply_stimulus(1, 30, 0, 0, 0);
    apply_stimulus(1, 31, 1, 0, 1);
    apply_stimulus(1, 32, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 1);
    apply_stimulus(1, 33, 1, 0, 1);
    check("pkt_cnt_commit_and_eop_read", int'(pkt0), 1);
    repeat (2) apply_stimulus(0, 0, 0, 0, 1);
    repeat (3) apply_stimulus(0, 0, 0, 0, 0);

    // Reset mid-packet with two packets committed.
    apply_stimulus(1, 40, 1, 0, 0);
    apply_stimulus(1, 41, 0, 0, 0);
    apply_stimulus(1, 42, 1, 0, 0);
    apply_stimulus(1, 43, 0, 0, 0);
    tb_rst = 1'b1; wr_en = 1'b1; wr_data = 32'd44; wr_eop = 1'b1; rd_en = 1'b1;
    @(posedge clk_tb); #1;
    tb_rst = 1'b0; wr_en = 1'b0; wr_data = '0; wr_eop = 1'b0; rd_en = 1'b0;
    model_reset();
    check("rst_mid_empty", int'(empty0), 1);
    check("rst_mid_pkt_cnt", int'(pkt0), 0);
    check("rst_mid_wr_level", int'(wl0), 0);
    check("rst_mid_rd_level", int'(rl1), 0);
    check_output();
    apply_stimulus(1, 50, 0, 0, 0);
    apply_stimulus(1, 51, 1, 0, 0);
    repeat (2) apply_stimulus(0, 0, 0, 0, 1);
    repeat (4) apply_stimulus(0, 0, 0, 0, 0);

    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
